// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 2-wide core: opcodes, slot record, issue-mask states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Opcode constants
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;

  // One decoded instruction slot. src fields are {used, reg[2:0]}.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [2:0] dest;
    logic       valid;
  } slot_t;

  // Issue-mask states, encoded as the {slot2, slot1} already-issued bits.
  localparam logic [1:0] FRESH   = 2'b00;
  localparam logic [1:0] S1_DONE = 2'b01;
  localparam logic [1:0] S2_DONE = 2'b10;
  localparam logic [1:0] BOTH    = 2'b11;

endpackage

// File: rtl/issue_mask_tracker.sv
// Tracks which slot of the held ID/RF pair already issued, plus hold-length counter and sticky timeout.
// Latency: iss_o is combinational from the current mask; mask/counter/timeout update on the next edge.
// Backpressure: enable_i=0 holds the pair and accumulates issued bits; enable_i=1 or flush_i restarts FRESH.
// Ports: clk_i, rst_ni (async active-low), flush_i, enable_i, vn_i {slot2,slot1} issue permission,
//        slot_vld_i {slot2,slot1} ID/RF valids, iss_o qualified issue, mask_o issued bits, timeout_o sticky flag.
module issue_mask_tracker
  import pipe_pkg::*;
#(
  parameter int MAX_HOLD = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       enable_i,
  input  logic [1:0] vn_i,
  input  logic [1:0] slot_vld_i,
  output logic [1:0] iss_o,
  output logic [1:0] mask_o,
  output logic       timeout_o
);

  localparam logic [2:0] MAX_HOLD_C = MAX_HOLD[2:0];

  logic [1:0] mask_q, mask_d;
  logic [2:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // A slot issues only if present, permitted, and not already sent from this held pair.
  assign iss_o = slot_vld_i & vn_i & ~mask_q;

  always_comb begin
    mask_d    = mask_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    if (flush_i || enable_i) begin
      // Pair leaves ID/RF (or is killed): the next pair starts clean.
      mask_d = FRESH;
      hold_d = 3'd0;
    end else begin
      mask_d = mask_q | iss_o;
      if (hold_q != 3'd7) begin
        hold_d = hold_q + 3'd1;
      end
    end
    if (!enable_i && (hold_q == MAX_HOLD_C)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= FRESH;
      hold_q    <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign mask_o    = mask_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/rf_ex_issue_register.sv
// RF/EX pipeline register of the 2-wide core with per-slot issue masking and branch flush.
// Latency: 1 cycle ID/RF -> RF/EX; id_rf_hold is combinational.
// Backpressure: enable=0 holds the pair in ID/RF; slots already issued from it are not reissued.
// Ports: clock, reset (async active-low), flush, enable, valid_next1/2, ID/RF slot fields and PC in,
//        RF/EX registered copies out, id_rf_hold, issued_mask {slot2,slot1}, hold_timeout (sticky).
// Optional: define ISSUE_PERF_CNT_EN to add perf_stall_cycles, perf_split_issues, perf_flushes.
module rf_ex_issue_register
  import pipe_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int MAX_HOLD = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            enable,
  input  logic            valid_next1,
  input  logic            valid_next2,
  input  logic [3:0]      opcode1_ID_RF,
  input  logic [3:0]      opcode2_ID_RF,
  input  logic [3:0]      src1_1_ID_RF,
  input  logic [3:0]      src2_1_ID_RF,
  input  logic [3:0]      src1_2_ID_RF,
  input  logic [3:0]      src2_2_ID_RF,
  input  logic [2:0]      dest_1_ID_RF,
  input  logic [2:0]      dest_2_ID_RF,
  input  logic [PC_W-1:0] PC_OUT_ID_RF,
  input  logic            Valid1_out_ID_RF,
  input  logic            Valid2_out_ID_RF,
  output logic [3:0]      opcode1_RF_EX,
  output logic [3:0]      opcode2_RF_EX,
  output logic [3:0]      src1_1_RF_EX,
  output logic [3:0]      src2_1_RF_EX,
  output logic [3:0]      src1_2_RF_EX,
  output logic [3:0]      src2_2_RF_EX,
  output logic [2:0]      dest_1_RF_EX,
  output logic [2:0]      dest_2_RF_EX,
  output logic [PC_W-1:0] PC_OUT_RF_EX,
  output logic            Valid1_out_RF_EX,
  output logic            Valid2_out_RF_EX,
  output logic            id_rf_hold,
  output logic [1:0]      issued_mask,
  output logic            hold_timeout
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]     perf_stall_cycles,
  output logic [15:0]     perf_split_issues,
  output logic [15:0]     perf_flushes
`endif
);

  logic [1:0]      iss;
  slot_t           s1_d, s2_d, s1_q, s2_q;
  logic [PC_W-1:0] pc_q;

  issue_mask_tracker #(
    .MAX_HOLD (MAX_HOLD)
  ) u_tracker (
    .clk_i      (clock),
    .rst_ni     (reset),
    .flush_i    (flush),
    .enable_i   (enable),
    .vn_i       ({valid_next2, valid_next1}),
    .slot_vld_i ({Valid2_out_ID_RF, Valid1_out_ID_RF}),
    .iss_o      (iss),
    .mask_o     (issued_mask),
    .timeout_o  (hold_timeout)
  );

  assign id_rf_hold = ~enable & ~flush;

  // Data fields copy every cycle, even while holding or flushing; only the
  // valids are qualified. The staller depends on PC_OUT_RF_EX tracking ID/RF.
  always_comb begin
    s1_d.opcode = opcode1_ID_RF;
    s1_d.src1   = src1_1_ID_RF;
    s1_d.src2   = src2_1_ID_RF;
    s1_d.dest   = dest_1_ID_RF;
    s1_d.valid  = iss[0] & ~flush;
    s2_d.opcode = opcode2_ID_RF;
    s2_d.src1   = src1_2_ID_RF;
    s2_d.src2   = src2_2_ID_RF;
    s2_d.dest   = dest_2_ID_RF;
    s2_d.valid  = iss[1] & ~flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      pc_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      pc_q <= PC_OUT_ID_RF;
    end
  end

  assign opcode1_RF_EX    = s1_q.opcode;
  assign src1_1_RF_EX     = s1_q.src1;
  assign src2_1_RF_EX     = s1_q.src2;
  assign dest_1_RF_EX     = s1_q.dest;
  assign Valid1_out_RF_EX = s1_q.valid;
  assign opcode2_RF_EX    = s2_q.opcode;
  assign src1_2_RF_EX     = s2_q.src1;
  assign src2_2_RF_EX     = s2_q.src2;
  assign dest_2_RF_EX     = s2_q.dest;
  assign Valid2_out_RF_EX = s2_q.valid;
  assign PC_OUT_RF_EX     = pc_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] stall_q, split_q, flushes_q;
  logic        split_ev;

  // Leaving FRESH with exactly one slot issued while the pair stays held.
  assign split_ev = ~flush & ~enable & (issued_mask == FRESH) &
                    ((iss == S1_DONE) || (iss == S2_DONE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      split_q   <= '0;
      flushes_q <= '0;
    end else begin
      if (!enable && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (split_ev && (split_q != 16'hFFFF)) begin
        split_q <= split_q + 16'd1;
      end
      if (flush && (flushes_q != 16'hFFFF)) begin
        flushes_q <= flushes_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_split_issues = split_q;
  assign perf_flushes      = flushes_q;
`endif

endmodule

// File: tb/tb_rf_ex_issue_register.sv
module tb_rf_ex_issue_register;

  localparam int PC_W     = 16;
  localparam int MAX_HOLD = 3;
  localparam int DW       = 30 + PC_W;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush, enable, valid_next1, valid_next2;
  logic [3:0]      opcode1_ID_RF, opcode2_ID_RF;
  logic [3:0]      src1_1_ID_RF, src2_1_ID_RF, src1_2_ID_RF, src2_2_ID_RF;
  logic [2:0]      dest_1_ID_RF, dest_2_ID_RF;
  logic [PC_W-1:0] PC_OUT_ID_RF;
  logic            Valid1_out_ID_RF, Valid2_out_ID_RF;
  logic [3:0]      opcode1_RF_EX, opcode2_RF_EX;
  logic [3:0]      src1_1_RF_EX, src2_1_RF_EX, src1_2_RF_EX, src2_2_RF_EX;
  logic [2:0]      dest_1_RF_EX, dest_2_RF_EX;
  logic [PC_W-1:0] PC_OUT_RF_EX;
  logic            Valid1_out_RF_EX, Valid2_out_RF_EX;
  logic            id_rf_hold;
  logic [1:0]      issued_mask;
  logic            hold_timeout;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0]     perf_stall_cycles, perf_split_issues, perf_flushes;
`endif

  always #5 clock = ~clock;

  rf_ex_issue_register #(.PC_W(PC_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset), .flush(flush), .enable(enable),
    .valid_next1(valid_next1), .valid_next2(valid_next2),
    .opcode1_ID_RF(opcode1_ID_RF), .opcode2_ID_RF(opcode2_ID_RF),
    .src1_1_ID_RF(src1_1_ID_RF), .src2_1_ID_RF(src2_1_ID_RF),
    .src1_2_ID_RF(src1_2_ID_RF), .src2_2_ID_RF(src2_2_ID_RF),
    .dest_1_ID_RF(dest_1_ID_RF), .dest_2_ID_RF(dest_2_ID_RF),
    .PC_OUT_ID_RF(PC_OUT_ID_RF),
    .Valid1_out_ID_RF(Valid1_out_ID_RF), .Valid2_out_ID_RF(Valid2_out_ID_RF),
    .opcode1_RF_EX(opcode1_RF_EX), .opcode2_RF_EX(opcode2_RF_EX),
    .src1_1_RF_EX(src1_1_RF_EX), .src2_1_RF_EX(src2_1_RF_EX),
    .src1_2_RF_EX(src1_2_RF_EX), .src2_2_RF_EX(src2_2_RF_EX),
    .dest_1_RF_EX(dest_1_RF_EX), .dest_2_RF_EX(dest_2_RF_EX),
    .PC_OUT_RF_EX(PC_OUT_RF_EX),
    .Valid1_out_RF_EX(Valid1_out_RF_EX), .Valid2_out_RF_EX(Valid2_out_RF_EX),
    .id_rf_hold(id_rf_hold), .issued_mask(issued_mask), .hold_timeout(hold_timeout)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_split_issues(perf_split_issues),
    .perf_flushes(perf_flushes)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-slot "already sent from the held pair" flags,
  // number of consecutive hold cycles, and the sticky timeout flag.
  bit          sent1, sent2;
  int          held;
  bit          tmo;
  bit          e_v1, e_v2;
  logic [DW-1:0] e_dat;
  int          p_stall, p_split, p_flush;

  function automatic logic [DW-1:0] din();
    return {opcode1_ID_RF, opcode2_ID_RF, src1_1_ID_RF, src2_1_ID_RF, src1_2_ID_RF,
            src2_2_ID_RF, dest_1_ID_RF, dest_2_ID_RF, PC_OUT_ID_RF};
  endfunction

  function automatic logic [DW-1:0] dout();
    return {opcode1_RF_EX, opcode2_RF_EX, src1_1_RF_EX, src2_1_RF_EX, src1_2_RF_EX,
            src2_2_RF_EX, dest_1_RF_EX, dest_2_RF_EX, PC_OUT_RF_EX};
  endfunction

  task automatic model_clear();
    sent1 = 0; sent2 = 0; held = 0; tmo = 0; e_v1 = 0; e_v2 = 0; e_dat = '0;
    p_stall = 0; p_split = 0; p_flush = 0;
  endtask

  task automatic rand_data();
    opcode1_ID_RF = 4'($urandom); opcode2_ID_RF = 4'($urandom);
    src1_1_ID_RF = 4'($urandom);  src2_1_ID_RF = 4'($urandom);
    src1_2_ID_RF = 4'($urandom);  src2_2_ID_RF = 4'($urandom);
    dest_1_ID_RF = 3'($urandom);  dest_2_ID_RF = 3'($urandom);
    PC_OUT_ID_RF = PC_W'($urandom);
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit go1, go2;
    go1 = Valid1_out_ID_RF && valid_next1 && !sent1;
    go2 = Valid2_out_ID_RF && valid_next2 && !sent2;
    if (!enable && held == MAX_HOLD) tmo = 1;
    if (!enable) p_stall++;
    if (flush) p_flush++;
    if (!flush && !enable && !sent1 && !sent2 && (go1 != go2)) p_split++;
    e_v1  = !flush && go1;
    e_v2  = !flush && go2;
    e_dat = din();
    if (flush || enable) begin
      sent1 = 0; sent2 = 0; held = 0;
    end else begin
      sent1 = sent1 || go1;
      sent2 = sent2 || go2;
      held  = (held < 7) ? held + 1 : 7;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; enable = 1; valid_next1 = 0; valid_next2 = 0;
    Valid1_out_ID_RF = 0; Valid2_out_ID_RF = 0;
    rand_data();
    reset = 0;
    @(posedge clock);
    #1;
    reset = 1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    enable = 1; valid_next1 = 1; valid_next2 = 1;
    Valid1_out_ID_RF = 1; Valid2_out_ID_RF = 1;
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX} !== 2'b11) begin
      n_bad++; $display("FAIL reset_pre_valids: got %b want 11", {Valid2_out_RF_EX, Valid1_out_RF_EX});
    end
    #2;
    reset = 0;
    #1;
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask, hold_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL reset_async_ctrl: got %b want 00000",
                        {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask, hold_timeout});
    end
    n_cmp++;
    if (dout() !== '0) begin
      n_bad++; $display("FAIL reset_async_data: got %h want 0", dout());
    end
    @(posedge clock);
    #1;
    reset = 1;
    model_clear();
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX} !== 2'b11) begin
      n_bad++; $display("FAIL reset_first_pair: got %b want 11", {Valid2_out_RF_EX, Valid1_out_RF_EX});
    end
  endtask

  task automatic test_split();
    do_reset();
    Valid1_out_ID_RF = 1; Valid2_out_ID_RF = 1;
    PC_OUT_ID_RF = 16'h0010;
    enable = 0; valid_next1 = 1; valid_next2 = 0;
    #1;
    n_cmp++;
    if (id_rf_hold !== 1'b1) begin
      n_bad++; $display("FAIL split_hold: got %b want 1", id_rf_hold);
    end
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask} !== 4'b0101) begin
      n_bad++; $display("FAIL split_c0: got %b want 0101", {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask});
    end
    enable = 1; valid_next1 = 1; valid_next2 = 1;
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask} !== 4'b1000) begin
      n_bad++; $display("FAIL split_c1: got %b want 1000", {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask});
    end
    n_cmp++;
    if (PC_OUT_RF_EX !== 16'h0010) begin
      n_bad++; $display("FAIL split_pc: got %h want 0010", PC_OUT_RF_EX);
    end
  endtask

  task automatic test_double_issue();
    do_reset();
    Valid1_out_ID_RF = 1; Valid2_out_ID_RF = 1;
    enable = 0; valid_next1 = 1; valid_next2 = 1;
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask} !== 4'b1111) begin
      n_bad++; $display("FAIL double_c0: got %b want 1111", {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask});
    end
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask} !== 4'b0011) begin
      n_bad++; $display("FAIL double_c1: got %b want 0011", {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask});
    end
  endtask

  task automatic test_flush();
    do_reset();
    Valid1_out_ID_RF = 1; Valid2_out_ID_RF = 1;
    enable = 0; valid_next1 = 1; valid_next2 = 0;
    tick();
    n_cmp++;
    if (issued_mask !== 2'b01) begin
      n_bad++; $display("FAIL flush_pre_mask: got %b want 01", issued_mask);
    end
    flush = 1; valid_next1 = 1; valid_next2 = 1;
    rand_data();
    #1;
    n_cmp++;
    if (id_rf_hold !== 1'b0) begin
      n_bad++; $display("FAIL flush_hold: got %b want 0", id_rf_hold);
    end
    tick();
    n_cmp++;
    if ({Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask} !== 4'b0000) begin
      n_bad++; $display("FAIL flush_ctrl: got %b want 0000", {Valid2_out_RF_EX, Valid1_out_RF_EX, issued_mask});
    end
    n_cmp++;
    if (dout() !== e_dat) begin
      n_bad++; $display("FAIL flush_data: got %h want %h", dout(), e_dat);
    end
`ifdef ISSUE_PERF_CNT_EN
    n_cmp++;
    if ({perf_stall_cycles, perf_split_issues, perf_flushes} !== {16'd2, 16'd1, 16'd1}) begin
      n_bad++; $display("FAIL flush_perf: got %0d/%0d/%0d want 2/1/1",
                        perf_stall_cycles, perf_split_issues, perf_flushes);
    end
`endif
    // Counter restarted at 0: MAX_HOLD further holds must not yet time out.
    flush = 0; valid_next1 = 0; valid_next2 = 0;
    for (int i = 0; i < MAX_HOLD; i++) tick();
    n_cmp++;
    if (hold_timeout !== 1'b0) begin
      n_bad++; $display("FAIL flush_cnt_clear: got %b want 0", hold_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 0;
    for (int i = 0; i < MAX_HOLD; i++) tick();
    n_cmp++;
    if (hold_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got %b want 0", hold_timeout);
    end
    tick();
    n_cmp++;
    if (hold_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_set: got %b want 1", hold_timeout);
    end
    enable = 1;
    tick();
    tick();
    n_cmp++;
    if (hold_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: got %b want 1", hold_timeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enable           = ($urandom_range(0, 99) < 45);
      flush            = ($urandom_range(0, 99) < 10);
      valid_next1      = 1'($urandom);
      valid_next2      = 1'($urandom);
      Valid1_out_ID_RF = ($urandom_range(0, 99) < 80);
      Valid2_out_ID_RF = ($urandom_range(0, 99) < 80);
      rand_data();
      #1;
      n_cmp++;
      if (id_rf_hold !== (!enable && !flush)) begin
        n_bad++; $display("FAIL rnd_hold c%0d: got %b want %b", c, id_rf_hold, (!enable && !flush));
      end
      tick();
      n_cmp++;
      if ({Valid2_out_RF_EX, Valid1_out_RF_EX} !== {e_v2, e_v1}) begin
        n_bad++; $display("FAIL rnd_valids c%0d: got %b want %b", c,
                          {Valid2_out_RF_EX, Valid1_out_RF_EX}, {e_v2, e_v1});
      end
      n_cmp++;
      if (issued_mask !== {sent2, sent1}) begin
        n_bad++; $display("FAIL rnd_mask c%0d: got %b want %b", c, issued_mask, {sent2, sent1});
      end
      n_cmp++;
      if (hold_timeout !== tmo) begin
        n_bad++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, hold_timeout, tmo);
      end
      n_cmp++;
      if (dout() !== e_dat) begin
        n_bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, dout(), e_dat);
      end
`ifdef ISSUE_PERF_CNT_EN
      n_cmp++;
      if ({perf_stall_cycles, perf_split_issues, perf_flushes} !==
          {16'(p_stall), 16'(p_split), 16'(p_flush)}) begin
        n_bad++; $display("FAIL rnd_perf c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                          perf_stall_cycles, perf_split_issues, perf_flushes, p_stall, p_split, p_flush);
      end
`endif
    end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_split();
    test_double_issue();
    test_flush();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
